hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Tracks the destination registers of the instructions in flight in EX, MEM
// and WB and compares them against the source operands of the instruction
// in ID. It produces the load-use stall and the per-operand forwarding
// selects for the ID/EX operand muxes.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid              ID holds a real instruction
//   id_ra, id_rb          ID source register indices
//   id_use_a, id_use_b    ID reads ra / rb (operand-usage decoder bit1 / bit0)
//   id_wr_en, id_wr_reg   ID writes a register, and which one
//   id_is_load            ID result only available at the end of MEM
//   pipe_hold             freeze the whole pipeline (entries and counter hold)
//   flush                 kill the ID instruction (wins over stall)
//   stall                 hold IF/ID and inject a bubble into EX
//   fwd_a, fwd_b          00 regfile, 01 EX, 10 MEM, 11 WB
//   stall_cnt             saturating count of stall cycles
module hazard_scoreboard #(
    parameter int unsigned REG_W = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             pipe_hold,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             vld;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             ld;
    } ent_t;

    ent_t             ex_q, mem_q, wb_q;
    ent_t             ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hit_ex_a, hit_mem_a, hit_wb_a;
    logic hit_ex_b, hit_mem_b, hit_wb_b;

    function automatic logic hit(input ent_t e, input logic [REG_W-1:0] src,
                                 input logic rd_en, input logic valid);
        return e.vld & e.wr & (e.rd == src) & rd_en & valid;
    endfunction

    // Youngest matching entry wins.
    function automatic logic [1:0] sel(input logic h_ex, input logic h_mem,
                                       input logic h_wb);
        if (h_ex)       return 2'b01;
        else if (h_mem) return 2'b10;
        else if (h_wb)  return 2'b11;
        else            return 2'b00;
    endfunction

    always_comb begin
        hit_ex_a  = hit(ex_q,  id_ra, id_use_a, id_valid);
        hit_mem_a = hit(mem_q, id_ra, id_use_a, id_valid);
        hit_wb_a  = hit(wb_q,  id_ra, id_use_a, id_valid);
        hit_ex_b  = hit(ex_q,  id_rb, id_use_b, id_valid);
        hit_mem_b = hit(mem_q, id_rb, id_use_b, id_valid);
        hit_wb_b  = hit(wb_q,  id_rb, id_use_b, id_valid);

        // Only a load still in EX cannot be forwarded in time; a flushed ID
        // instruction never stalls.
        stall = (hit_ex_a | hit_ex_b) & ex_q.ld & ~flush;

        fwd_a = sel(hit_ex_a, hit_mem_a, hit_wb_a);
        fwd_b = sel(hit_ex_b, hit_mem_b, hit_wb_b);
    end

    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.vld = 1'b1;
            ex_d.wr  = id_wr_en;
            ex_d.rd  = id_wr_reg;
            ex_d.ld  = id_is_load;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else if (!pipe_hold) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule
